// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB transmit serializer
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC,
    DONE
  } tx_state_e;

  localparam int CRC5_LEN  = 5;
  localparam int CRC16_LEN = 16;
  localparam int STUFF_RUN = 6;

endpackage

// File: rtl/usb_tx_serializer_if.sv
// rtl/usb_tx_serializer_if.sv - word-load handshake between packet controller and serializer
interface usb_tx_serializer_if #(
  parameter int DATA_W = 8
) ();

  logic              sync_ld;
  logic              tx_load;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              crc16_mode;
  logic              tx_ready;

  modport master (
    output sync_ld, tx_load, tx_data, tx_last, crc16_mode,
    input  tx_ready
  );

  modport slave (
    input  sync_ld, tx_load, tx_data, tx_last, crc16_mode,
    output tx_ready
  );

endinterface

// File: rtl/usb_tx_fifo.sv
// rtl/usb_tx_fifo.sv - DEPTH-entry circular word buffer, registered head (no fall-through)
module usb_tx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign occupancy = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;

  // Next pointers, count and storage; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - USB transmit serializer top; USB_TX_BITSTUFF_EN enables the internal bit stuffer
module usb_tx_serializer
  import usb_tx_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 2,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = 8'h80
) (
  input  logic                   clock,
  input  logic                   reset,
  usb_tx_serializer_if.slave     ld,
  input  logic                   halt_tx_shift,
  output logic                   tdo,
  output logic                   tcs,
  output logic                   last_bit,
  output logic                   shift_crc16,
  output logic                   shift_crc5,
  output logic                   pkt_done,
  output logic                   tx_underrun,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int BW         = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BIT_LAST_I = DATA_W - 1;
  localparam int CRC5_I     = CRC5_LEN - 1;
  localparam int CRC16_I    = CRC16_LEN - 1;
  localparam logic [BW-1:0] BIT_LAST   = BIT_LAST_I[BW-1:0];
  localparam logic [4:0]    CRC5_LAST  = CRC5_I[4:0];
  localparam logic [4:0]    CRC16_LAST = CRC16_I[4:0];

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sh_word_q, sh_word_d;
  logic              sh_last_q, sh_last_d;
  logic              sh_valid_q, sh_valid_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [4:0]        crc_cnt_q, crc_cnt_d;
  logic              mode16_q, mode16_d;
  logic              underrun_q, underrun_d;
  logic              last_acc_q, last_acc_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [DATA_W:0]   fifo_wdata, fifo_rdata;
  logic              halt_int, halt_eff, ready, sync_go, data_go, bit_final;
  logic [4:0]        crc_last;

  assign halt_eff  = halt_tx_shift | halt_int;
  assign ready     = ~fifo_full & ~halt_eff & ~last_acc_q & (state_q != CRC) & (state_q != DONE);
  assign sync_go   = ld.sync_ld & (state_q == IDLE) & fifo_empty & ~halt_eff;
  assign data_go   = ld.tx_load & ready & (state_q == DATA);
  assign bit_final = sh_valid_q & (bit_cnt_q == BIT_LAST);
  assign crc_last  = mode16_q ? CRC16_LAST : CRC5_LAST;

  // SYNC is pushed untagged; payload words carry their last tag in the top bit
  assign fifo_push  = sync_go | data_go;
  assign fifo_wdata = sync_go ? {1'b0, SYNC_PATTERN} : {ld.tx_last, ld.tx_data};

  assign ld.tx_ready = ready & ~reset;
  assign tcs         = sh_valid_q & ~halt_eff;
  assign tdo         = (sh_valid_q & ~halt_int) ? sh_word_q[bit_cnt_q] : 1'b0;
  assign last_bit    = bit_final & sh_last_q;
  assign shift_crc16 = (state_q == CRC) & mode16_q;
  assign shift_crc5  = (state_q == CRC) & ~mode16_q;
  assign pkt_done    = (state_q == DONE);
  assign tx_underrun = underrun_q;

  usb_tx_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .wdata     (fifo_wdata),
    .pop       (fifo_pop),
    .rdata     (fifo_rdata),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .occupancy (occupancy)
  );

`ifdef USB_TX_BITSTUFF_EN
  logic [2:0] ones_q, ones_d;
  localparam logic [2:0] RUN_LEN = STUFF_RUN[2:0];

  assign halt_int = (state_q == DATA) & (ones_q == RUN_LEN);

  // Ones-run tracker: counts emitted 1s, clears on a 0, a stuffed bit, or outside DATA
  always_comb begin
    ones_d = ones_q;
    if (state_q != DATA) begin
      ones_d = '0;
    end else if (halt_int) begin
      if (!halt_tx_shift) ones_d = '0;
    end else if (sh_valid_q && !halt_tx_shift) begin
      ones_d = sh_word_q[bit_cnt_q] ? ones_q + 3'd1 : 3'd0;
    end
  end

  // Ones-run register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ones_q <= '0;
    else       ones_q <= ones_d;
  end
`else
  assign halt_int = 1'b0;
`endif

  // Shifter: advance one bit per unhalted cycle, reload from the buffer with no gap bit
  always_comb begin
    sh_word_d  = sh_word_q;
    sh_last_d  = sh_last_q;
    sh_valid_d = sh_valid_q;
    bit_cnt_d  = bit_cnt_q;
    fifo_pop   = 1'b0;
    if (!halt_eff && state_q == DATA) begin
      if (!sh_valid_q || bit_final) begin
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          sh_word_d  = fifo_rdata[DATA_W-1:0];
          sh_last_d  = fifo_rdata[DATA_W];
          sh_valid_d = 1'b1;
          fifo_pop   = 1'b1;
        end else begin
          sh_valid_d = 1'b0;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // Packet sequencer: SYNC/payload, CRC window, done pulse, underrun abort
  always_comb begin
    state_d    = state_q;
    crc_cnt_d  = crc_cnt_q;
    mode16_d   = mode16_q;
    underrun_d = underrun_q;
    last_acc_d = last_acc_q;
    fifo_flush = 1'b0;
    if (!halt_eff) begin
      case (state_q)
        IDLE: begin
          if (sync_go) begin
            state_d    = DATA;
            mode16_d   = ld.crc16_mode;
            underrun_d = 1'b0;
          end
        end
        DATA: begin
          if (bit_final && sh_last_q) begin
            state_d   = CRC;
            crc_cnt_d = '0;
          end else if (!sh_valid_q && fifo_empty && !last_acc_q && !data_go) begin
            state_d    = IDLE;
            underrun_d = 1'b1;
            fifo_flush = 1'b1;
          end
        end
        CRC: begin
          if (crc_cnt_q == crc_last) state_d = DONE;
          else                       crc_cnt_d = crc_cnt_q + 5'd1;
        end
        default: state_d = IDLE;
      endcase
    end
    if (data_go && ld.tx_last) last_acc_d = 1'b1;
    if (state_d == IDLE && state_q != IDLE) last_acc_d = 1'b0;
  end

  // Sequencer and shifter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sh_word_q  <= '0;
      sh_last_q  <= 1'b0;
      sh_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
      crc_cnt_q  <= '0;
      mode16_q   <= 1'b0;
      underrun_q <= 1'b0;
      last_acc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_word_q  <= sh_word_d;
      sh_last_q  <= sh_last_d;
      sh_valid_q <= sh_valid_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_cnt_q  <= crc_cnt_d;
      mode16_q   <= mode16_d;
      underrun_q <= underrun_d;
      last_acc_q <= last_acc_d;
    end
  end

endmodule
